// File: rtl/dbg_ctrl_pkg.sv
// Shared types and constants for the debug run-control block (dbg_ctrl).
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } dbg_state_t;

    // Winning request after priority resolution: halt > step > run.
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_RUN  = 2'd1,
        REQ_STEP = 2'd2,
        REQ_HALT = 2'd3
    } dbg_req_t;

    localparam int STEP_MIN = 1;

    function automatic dbg_req_t req_prio(input logic halt_req,
                                          input logic step_req,
                                          input logic run_req);
        if (halt_req)      return REQ_HALT;
        else if (step_req) return REQ_STEP;
        else if (run_req)  return REQ_RUN;
        else               return REQ_NONE;
    endfunction

endpackage

// File: rtl/dbg_ctrl_if.sv
// Debug port bundle between the external debugger/core and dbg_ctrl.
// DBG_INSTR_CNT_EN adds the retired-instruction counter output.
interface dbg_ctrl_if #(
    parameter int WIDTH    = 8,
    parameter int BP_IDX_W = 2
);
    logic [WIDTH-1:0]    pc;
    logic                halt_req;
    logic                run_req;
    logic                step_req;
    logic [WIDTH-1:0]    step_n;
    logic                bp_wr;
    logic [BP_IDX_W-1:0] bp_idx;
    logic [WIDTH-1:0]    bp_addr;
    logic                bp_valid;
    logic                cpu_en;
    logic                halted;
    logic                bp_hit;
    logic [BP_IDX_W-1:0] bp_hit_idx;
    logic                step_busy;
`ifdef DBG_INSTR_CNT_EN
    logic [31:0]         instr_cnt;
`endif

    modport master (
        output pc, halt_req, run_req, step_req, step_n,
        output bp_wr, bp_idx, bp_addr, bp_valid,
`ifdef DBG_INSTR_CNT_EN
        input  instr_cnt,
`endif
        input  cpu_en, halted, bp_hit, bp_hit_idx, step_busy
    );

    modport slave (
        input  pc, halt_req, run_req, step_req, step_n,
        input  bp_wr, bp_idx, bp_addr, bp_valid,
`ifdef DBG_INSTR_CNT_EN
        output instr_cnt,
`endif
        output cpu_en, halted, bp_hit, bp_hit_idx, step_busy
    );

endinterface

// File: rtl/dbg_bp_unit.sv
// Hardware breakpoint slots with parallel PC comparators; reports any match
// and the lowest matching slot index.
module dbg_bp_unit #(
    parameter int WIDTH    = 8,
    parameter int BP_NUM   = 4,
    parameter int BP_IDX_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    pc,
    input  logic                bp_wr,
    input  logic [BP_IDX_W-1:0] bp_idx,
    input  logic [WIDTH-1:0]    bp_addr,
    input  logic                bp_valid,
    output logic                bp_match,
    output logic [BP_IDX_W-1:0] bp_match_idx
);

    logic [WIDTH-1:0] slot_addr  [BP_NUM];
    logic             slot_valid [BP_NUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BP_NUM; i++) begin
                slot_addr[i]  <= '0;
                slot_valid[i] <= 1'b0;
            end
        end else if (bp_wr) begin
            slot_addr[bp_idx]  <= bp_addr;
            slot_valid[bp_idx] <= bp_valid;
        end
    end

    // Scan downward so the lowest matching slot is the last one assigned.
    always_comb begin
        bp_match     = 1'b0;
        bp_match_idx = '0;
        for (int i = BP_NUM - 1; i >= 0; i--) begin
            if (slot_valid[i] && (slot_addr[i] == pc)) begin
                bp_match     = 1'b1;
                bp_match_idx = BP_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/dbg_ctrl.sv
// Run-control sequencer: Run/Halt/Step and PC breakpoints, producing cpu_en.
// Optional DBG_INSTR_CNT_EN adds a free-running executed-instruction counter.
//
//   state | meaning
//   HALT  | core frozen, waiting for run/step request
//   RUN   | free run until halt request or breakpoint
//   STEP  | execute cnt instructions, then HALT
module dbg_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BP_NUM     = 4,
    parameter int BP_IDX_W   = 2,
    parameter int RUN_ON_RST = 0
) (
    input  logic      clk,
    input  logic      rst,
    dbg_ctrl_if.slave dbg
);

    dbg_state_t          state_q, state_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                skip_q, skip_d;
    logic                hit_q, hit_d;
    logic [BP_IDX_W-1:0] hit_idx_q, hit_idx_d;
    logic                bp_match;
    logic [BP_IDX_W-1:0] bp_match_idx;
    logic                bp_block;
    logic                active;
    dbg_req_t            req;

    dbg_bp_unit #(
        .WIDTH    (WIDTH),
        .BP_NUM   (BP_NUM),
        .BP_IDX_W (BP_IDX_W)
    ) u_bp (
        .clk          (clk),
        .rst          (rst),
        .pc           (dbg.pc),
        .bp_wr        (dbg.bp_wr),
        .bp_idx       (dbg.bp_idx),
        .bp_addr      (dbg.bp_addr),
        .bp_valid     (dbg.bp_valid),
        .bp_match     (bp_match),
        .bp_match_idx (bp_match_idx)
    );

    assign bp_block = bp_match && !skip_q;
    assign active   = (state_q == RUN) || (state_q == STEP);
    assign req      = req_prio(dbg.halt_req, dbg.step_req, dbg.run_req);

    assign dbg.cpu_en     = active && !bp_block;
    assign dbg.halted     = (state_q == HALT);
    assign dbg.step_busy  = (state_q == STEP);
    assign dbg.bp_hit     = hit_q;
    assign dbg.bp_hit_idx = hit_idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (RUN_ON_RST != 0) ? RUN : HALT;
            cnt_q     <= '0;
            skip_q    <= 1'b0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            skip_q    <= skip_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        skip_d    = skip_q;
        hit_d     = 1'b0;
        hit_idx_d = hit_idx_q;
        case (state_q)
            HALT: begin
                case (req)
                    REQ_STEP: begin
                        state_d = STEP;
                        cnt_d   = (dbg.step_n == '0) ? WIDTH'(STEP_MIN) : dbg.step_n;
                        skip_d  = 1'b1;
                    end
                    REQ_RUN: begin
                        state_d = RUN;
                        skip_d  = 1'b1;
                    end
                    default: ;
                endcase
            end
            RUN: begin
                skip_d = 1'b0;
                // Breakpoint outranks a coincident halt so the reason is reported.
                if (bp_block) begin
                    state_d   = HALT;
                    hit_d     = 1'b1;
                    hit_idx_d = bp_match_idx;
                end else if (req == REQ_HALT) begin
                    state_d = HALT;
                end
            end
            STEP: begin
                skip_d = 1'b0;
                if (bp_block) begin
                    state_d   = HALT;
                    hit_d     = 1'b1;
                    hit_idx_d = bp_match_idx;
                    cnt_d     = '0;
                end else if (req == REQ_HALT) begin
                    state_d = HALT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                    if (cnt_q == WIDTH'(STEP_MIN)) state_d = HALT;
                end
            end
            default: state_d = HALT;
        endcase
    end

`ifdef DBG_INSTR_CNT_EN
    logic [31:0] instr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)             instr_cnt_q <= '0;
        else if (dbg.cpu_en) instr_cnt_q <= instr_cnt_q + 32'd1;
    end

    assign dbg.instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_dbg_ctrl.sv
// Directed bench for dbg_ctrl: reset, breakpoints, resume-skip, stepping,
// request priority; instruction counter when DBG_INSTR_CNT_EN is defined.
module tb_dbg_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   en_cnt;

    always #5 clk = ~clk;

    dbg_ctrl_if #(.WIDTH(8), .BP_IDX_W(2)) dif ();

    dbg_ctrl #(
        .WIDTH      (8),
        .BP_NUM     (4),
        .BP_IDX_W   (2),
        .RUN_ON_RST (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .dbg (dif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One core cycle: the bench plays the core, advancing pc when cpu_en was high.
    task automatic tick();
        logic e;
        e = dif.cpu_en;
        @(posedge clk);
        #1;
        if (e) dif.pc = dif.pc + 8'd1;
        #1;
    endtask

    task automatic bp_write(input logic [1:0] idx, input logic [7:0] addr, input logic v);
        dif.bp_wr    = 1'b1;
        dif.bp_idx   = idx;
        dif.bp_addr  = addr;
        dif.bp_valid = v;
        tick();
        dif.bp_wr    = 1'b0;
    endtask

    task automatic count_step(input logic [7:0] n);
        dif.step_req = 1'b1;
        dif.step_n   = n;
        tick();
        dif.step_req = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (dif.halted) break;
            if (dif.cpu_en) en_cnt++;
            tick();
        end
    endtask

    initial begin
        dif.pc = 8'h00;
        dif.halt_req = 1'b0;
        dif.run_req = 1'b1;
        dif.step_req = 1'b0;
        dif.step_n = 8'h00;
        dif.bp_wr = 1'b0;
        dif.bp_idx = 2'd0;
        dif.bp_addr = 8'h00;
        dif.bp_valid = 1'b0;

        tick(); tick();
        chk("rst_halted", dif.halted, 1);
        chk("rst_cpu_en", dif.cpu_en, 0);
        chk("rst_bp_hit", dif.bp_hit, 0);
        chk("rst_hit_idx", dif.bp_hit_idx, 0);
        chk("rst_step_busy", dif.step_busy, 0);

        rst = 1'b0;
        dif.run_req = 1'b0;
        bp_write(2'd2, 8'h05, 1'b1);
        chk("halt_after_rst", dif.cpu_en, 0);

        dif.run_req = 1'b1;
        tick();
        dif.run_req = 1'b0;
        chk("run_cpu_en", dif.cpu_en, 1);
        chk("run_halted", dif.halted, 0);

        repeat (5) tick();
        chk("bp_pc", dif.pc, 8'h05);
        chk("bp_block_en", dif.cpu_en, 0);
        tick();
        chk("bp_halted", dif.halted, 1);
        chk("bp_hit_pulse", dif.bp_hit, 1);
        chk("bp_hit_idx2", dif.bp_hit_idx, 2);
        chk("bp_pc_hold", dif.pc, 8'h05);
        tick();
        chk("bp_hit_once", dif.bp_hit, 0);
        chk("bp_idx_held", dif.bp_hit_idx, 2);

        dif.run_req = 1'b1;
        tick();
        dif.run_req = 1'b0;
        chk("resume_en", dif.cpu_en, 1);
        tick();
        chk("resume_pc", dif.pc, 8'h06);
        chk("resume_running", dif.halted, 0);
        tick(); tick();
        chk("resume_no_rehalt", dif.cpu_en, 1);
        chk("resume_pc8", dif.pc, 8'h08);

        dif.halt_req = 1'b1;
        tick();
        dif.halt_req = 1'b0;
        chk("halt_halted", dif.halted, 1);
        chk("halt_last_exec", dif.pc, 8'h09);
        chk("halt_cpu_en", dif.cpu_en, 0);

        count_step(8'd3);
        chk("step3_cycles", en_cnt, 3);
        chk("step3_halted", dif.halted, 1);
        chk("step3_pc", dif.pc, 8'h0C);

        count_step(8'd0);
        chk("step0_cycles", en_cnt, 1);
        chk("step0_pc", dif.pc, 8'h0D);

        dif.halt_req = 1'b1;
        dif.step_req = 1'b1;
        dif.step_n   = 8'd3;
        tick();
        dif.halt_req = 1'b0;
        dif.step_req = 1'b0;
        chk("prio_halt", dif.halted, 1);
        chk("prio_no_step", dif.step_busy, 0);

        bp_write(2'd1, 8'h0F, 1'b1);
        bp_write(2'd0, 8'h0F, 1'b1);
        dif.run_req = 1'b1;
        tick();
        dif.run_req = 1'b0;
        tick(); tick();
        chk("bp2_pc", dif.pc, 8'h0F);
        chk("bp2_block", dif.cpu_en, 0);
        dif.halt_req = 1'b1;
        tick();
        dif.halt_req = 1'b0;
        chk("bp_halt_halted", dif.halted, 1);
        chk("bp_halt_hit", dif.bp_hit, 1);
        chk("bp_lowest_idx", dif.bp_hit_idx, 0);

`ifdef DBG_INSTR_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("icnt_rst", dif.instr_cnt, 0);
        dif.pc = 8'h40;
        dif.run_req = 1'b1;
        tick();
        dif.run_req = 1'b0;
        repeat (9) tick();
        dif.halt_req = 1'b1;
        tick();
        dif.halt_req = 1'b0;
        chk("icnt_run10", dif.instr_cnt, 10);
        count_step(8'd2);
        chk("icnt_12", dif.instr_cnt, 12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("icnt_rst2", dif.instr_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
